// File: rtl/calc_pkg.sv
// Shared encodings for the four-digit BCD calculator control path.
// States, key codes and ALU op codes used by the sequencer and its helpers.
package calc_pkg;

    localparam logic [2:0] S_ENTER_A = 3'd0;
    localparam logic [2:0] S_OP_WAIT = 3'd1;
    localparam logic [2:0] S_ENTER_B = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_RESULT  = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    typedef enum logic [2:0] {
        ENTER_A = S_ENTER_A,
        OP_WAIT = S_OP_WAIT,
        ENTER_B = S_ENTER_B,
        EXEC    = S_EXEC,
        RESULT  = S_RESULT,
        ERR     = S_ERR
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_MUL = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    function automatic logic [1:0] key_to_op(
        input logic [3:0] code
    );
        logic [1:0] op;
        op = OP_ADD;
        if (code == KEY_SUB)
            op = OP_SUB;
        else if (code == KEY_MUL)
            op = OP_MUL;
        return op;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// BCD operand entry register: shifts digits in from the right,
// counts them and silently drops digits once the operand is full.
module bcd_entry_reg #(
    parameter int NDIG = 4,
    parameter int CW   = $clog2(NDIG + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic [CW-1:0]     load_cnt,
    input  logic              shift,
    input  logic [3:0]        digit,
    output logic [4*NDIG-1:0] value,
    output logic [CW-1:0]     count
);

    logic room;

    assign room = (count < CW'(NDIG));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
            count <= '0;
        end else if (clr) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_val;
            count <= load_cnt;
        end else if (shift && room) begin
            value <= {value[4*NDIG-5:0], digit};
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand entry, operator latch, ALU launch
// with a timeout watchdog, result latch and display selection.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              alu_done,
    input  logic [4*NDIG-1:0] alu_result,
    input  logic              alu_ovf,
    output logic [4*NDIG-1:0] operand_a,
    output logic [4*NDIG-1:0] operand_b,
    output logic [1:0]        alu_op,
    output logic              alu_start,
    output logic [4*NDIG-1:0] disp_bcd,
    output logic              busy,
    output logic              err,
    output logic [2:0]        state_dbg
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    state_t state_q, state_d;

    logic [1:0]    op_q, op_d;
    logic          op_ld;
    logic [W-1:0]  res_q;
    logic          res_ld, res_clr;
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;
    logic          exec_go;
    logic          start_q;

    logic          a_clr, a_load, a_shift;
    logic [W-1:0]  a_val;
    logic [CW-1:0] a_cnt, a_count;
    logic          b_clr, b_load, b_shift;
    logic [W-1:0]  b_val;
    logic [CW-1:0] b_cnt, b_count;

    logic          key_dig, key_op;
    logic          key_clr, key_eq;
    logic [W-1:0]  dig_ext;

    assign key_dig = key_valid && (key_code <= 4'd9);
    assign key_op  = key_valid && (key_code == KEY_ADD
                   || key_code == KEY_SUB
                   || key_code == KEY_MUL);
    assign key_clr = key_valid && (key_code == KEY_CLR);
    assign key_eq  = key_valid && (key_code == KEY_EQ);
    assign dig_ext = {{(W-4){1'b0}}, key_code};

    // Counter runs 0..ALU_TIMEOUT-1 while in EXEC; last value expires.
    assign tmo_hit = (tmo_q == TW'(ALU_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        op_ld   = 1'b0;
        op_d    = key_to_op(key_code);
        res_ld  = 1'b0;
        res_clr = 1'b0;
        exec_go = 1'b0;
        a_clr   = 1'b0;
        a_load  = 1'b0;
        a_shift = 1'b0;
        a_val   = '0;
        a_cnt   = '0;
        b_clr   = 1'b0;
        b_load  = 1'b0;
        b_shift = 1'b0;
        b_val   = '0;
        b_cnt   = '0;
        if (key_clr) begin
            state_d = ENTER_A;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            res_clr = 1'b1;
            op_ld   = 1'b1;
            op_d    = OP_ADD;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (key_dig) begin
                        a_shift = 1'b1;
                    end else if (key_op) begin
                        op_ld   = 1'b1;
                        state_d = OP_WAIT;
                    end
                end
                OP_WAIT: begin
                    if (key_op) begin
                        op_ld = 1'b1;
                    end else if (key_dig) begin
                        b_load  = 1'b1;
                        b_val   = dig_ext;
                        b_cnt   = CW'(1);
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (key_dig) begin
                        b_shift = 1'b1;
                    end else if (key_eq) begin
                        exec_go = 1'b1;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        res_ld  = !alu_ovf;
                        state_d = alu_ovf ? ERR : RESULT;
                    end else if (tmo_hit) begin
                        state_d = ERR;
                    end
                end
                RESULT: begin
                    if (key_dig) begin
                        a_load  = 1'b1;
                        a_val   = dig_ext;
                        a_cnt   = CW'(1);
                        b_clr   = 1'b1;
                        state_d = ENTER_A;
                    end else if (key_op) begin
                        a_load  = 1'b1;
                        a_val   = res_q;
                        a_cnt   = CW'(NDIG);
                        b_clr   = 1'b1;
                        op_ld   = 1'b1;
                        state_d = OP_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
            op_q    <= OP_ADD;
            res_q   <= '0;
            tmo_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= exec_go;
            if (op_ld)
                op_q <= op_d;
            if (res_clr)
                res_q <= '0;
            else if (res_ld)
                res_q <= alu_result;
            if (exec_go || key_clr)
                tmo_q <= '0;
            else if (state_q == EXEC)
                tmo_q <= tmo_q + TW'(1);
        end
    end

    bcd_entry_reg #(.NDIG(NDIG), .CW(CW)) u_reg_a (
        .clk      (clk),
        .reset    (reset),
        .clr      (a_clr),
        .load     (a_load),
        .load_val (a_val),
        .load_cnt (a_cnt),
        .shift    (a_shift),
        .digit    (key_code),
        .value    (operand_a),
        .count    (a_count)
    );

    bcd_entry_reg #(.NDIG(NDIG), .CW(CW)) u_reg_b (
        .clk      (clk),
        .reset    (reset),
        .clr      (b_clr),
        .load     (b_load),
        .load_val (b_val),
        .load_cnt (b_cnt),
        .shift    (b_shift),
        .digit    (key_code),
        .value    (operand_b),
        .count    (b_count)
    );

    always_comb begin
        disp_bcd = '0;
        case (state_q)
            ENTER_A, OP_WAIT: disp_bcd = operand_a;
            ENTER_B, EXEC:    disp_bcd = operand_b;
            RESULT:           disp_bcd = res_q;
            default:          disp_bcd = '0;
        endcase
    end

    assign alu_op    = op_q;
    assign alu_start = start_q;
    assign busy      = (state_q == EXEC);
    assign err       = (state_q == ERR);
    assign state_dbg = state_q;

    logic unused_cnt;
    assign unused_cnt = ^{a_count, b_count};

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
// Keys are driven between edges and outputs sampled on the falling edge.
module tb_calc_sequencer;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_ovf;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic [15:0] disp_bcd;
    logic        busy;
    logic        err;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    calc_sequencer #(.NDIG(4), .ALU_TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .disp_bcd   (disp_bcd),
        .busy       (busy),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (alu_start)
            start_cnt++;

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'hF;
    endtask

    task automatic alu_resp(input logic [15:0] r, input logic ovf);
        @(negedge clk);
        alu_done   = 1'b1;
        alu_result = r;
        alu_ovf    = ovf;
        @(negedge clk);
        alu_done   = 1'b0;
        alu_result = 16'h0;
        alu_ovf    = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++)
            @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        total++;
        if (state_dbg !== 3'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=0", state_dbg);
        end
        total++;
        if ({operand_a, operand_b, disp_bcd} !== 48'h0) begin
            bad++;
            $display("FAIL reset_regs got=%h/%h/%h exp=0",
                     operand_a, operand_b, disp_bcd);
        end
        total++;
        if ({alu_op, alu_start, busy, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=00000",
                     {alu_op, alu_start, busy, err});
        end
    endtask

    task automatic test_basic_add;
        int s0;
        s0 = start_cnt;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'hA);
        press(4'h4);
        press(4'h5);
        press(4'hE);
        total++;
        if (alu_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL add_launch got=start%b busy%b exp=11",
                     alu_start, busy);
        end
        wait_cycles(2);
        total++;
        if (operand_a !== 16'h0123 || operand_b !== 16'h0045) begin
            bad++;
            $display("FAIL add_operands got=%h/%h exp=0123/0045",
                     operand_a, operand_b);
        end
        total++;
        if (alu_op !== 2'b00 || alu_start !== 1'b0) begin
            bad++;
            $display("FAIL add_op got=op%b start%b exp=00/0",
                     alu_op, alu_start);
        end
        alu_resp(16'h0168, 1'b0);
        total++;
        if (start_cnt - s0 !== 1) begin
            bad++;
            $display("FAIL add_start_count got=%0d exp=1",
                     start_cnt - s0);
        end
        total++;
        if (state_dbg !== 3'd4 || disp_bcd !== 16'h0168) begin
            bad++;
            $display("FAIL add_result got=st%0d disp%h exp=4/0168",
                     state_dbg, disp_bcd);
        end
    endtask

    task automatic test_chain_ovf;
        press(4'hA);
        total++;
        if (state_dbg !== 3'd1 || operand_a !== 16'h0168) begin
            bad++;
            $display("FAIL chain_load got=st%0d a%h exp=1/0168",
                     state_dbg, operand_a);
        end
        press(4'h2);
        press(4'hE);
        total++;
        if (operand_a !== 16'h0168 || operand_b !== 16'h0002) begin
            bad++;
            $display("FAIL chain_operands got=%h/%h exp=0168/0002",
                     operand_a, operand_b);
        end
        alu_resp(16'h9999, 1'b1);
        total++;
        if (state_dbg !== 3'd5 || err !== 1'b1 || disp_bcd !== 16'h0) begin
            bad++;
            $display("FAIL chain_ovf got=st%0d err%b disp%h exp=5/1/0",
                     state_dbg, err, disp_bcd);
        end
        press(4'hC);
        total++;
        if (state_dbg !== 3'd0 || operand_a !== 16'h0) begin
            bad++;
            $display("FAIL chain_clear got=st%0d a%h exp=0/0",
                     state_dbg, operand_a);
        end
    endtask

    task automatic test_digit_drop_timeout;
        press(4'h9);
        press(4'h8);
        press(4'h7);
        press(4'h6);
        press(4'h5);
        total++;
        if (operand_a !== 16'h9876 || disp_bcd !== 16'h9876) begin
            bad++;
            $display("FAIL drop_a got=%h disp%h exp=9876",
                     operand_a, disp_bcd);
        end
        press(4'hE);
        total++;
        if (state_dbg !== 3'd0) begin
            bad++;
            $display("FAIL eq_in_a got=%0d exp=0", state_dbg);
        end
        press(4'hB);
        press(4'hB);
        press(4'hD);
        total++;
        if (alu_op !== 2'b10 || state_dbg !== 3'd1) begin
            bad++;
            $display("FAIL op_replace got=op%b st%0d exp=10/1",
                     alu_op, state_dbg);
        end
        press(4'h1);
        total++;
        if (operand_b !== 16'h0001 || disp_bcd !== 16'h0001
            || state_dbg !== 3'd2) begin
            bad++;
            $display("FAIL b_first got=b%h disp%h st%0d exp=0001/0001/2",
                     operand_b, disp_bcd, state_dbg);
        end
        press(4'hE);
        wait_cycles(10);
        total++;
        if (busy !== 1'b1 || err !== 1'b0 || alu_op !== 2'b10) begin
            bad++;
            $display("FAIL tmo_pending got=busy%b err%b op%b exp=1/0/10",
                     busy, err, alu_op);
        end
        wait_cycles(60);
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || disp_bcd !== 16'h0) begin
            bad++;
            $display("FAIL tmo_err got=err%b busy%b disp%h exp=1/0/0",
                     err, busy, disp_bcd);
        end
        press(4'h7);
        total++;
        if (state_dbg !== 3'd5 || operand_a !== 16'h9876) begin
            bad++;
            $display("FAIL err_ignore got=st%0d a%h exp=5/9876",
                     state_dbg, operand_a);
        end
        press(4'hC);
        total++;
        if (state_dbg !== 3'd0 || operand_a !== 16'h0
            || alu_op !== 2'b00) begin
            bad++;
            $display("FAIL err_clear got=st%0d a%h op%b exp=0/0/00",
                     state_dbg, operand_a, alu_op);
        end
    endtask

    task automatic test_clear_vs_done;
        press(4'h5);
        press(4'hA);
        press(4'h3);
        press(4'hE);
        @(negedge clk);
        key_valid  = 1'b1;
        key_code   = 4'hC;
        alu_done   = 1'b1;
        alu_result = 16'h0008;
        @(negedge clk);
        key_valid  = 1'b0;
        key_code   = 4'hF;
        alu_done   = 1'b0;
        alu_result = 16'h0;
        total++;
        if (state_dbg !== 3'd0 || disp_bcd !== 16'h0
            || operand_b !== 16'h0) begin
            bad++;
            $display("FAIL clr_beats_done got=st%0d disp%h b%h exp=0/0/0",
                     state_dbg, disp_bcd, operand_b);
        end
        alu_resp(16'h0008, 1'b0);
        total++;
        if (state_dbg !== 3'd0 || disp_bcd !== 16'h0) begin
            bad++;
            $display("FAIL late_done got=st%0d disp%h exp=0/0",
                     state_dbg, disp_bcd);
        end
    endtask

    task automatic test_reset_mid_exec;
        press(4'h1);
        press(4'hD);
        press(4'h2);
        press(4'hE);
        total++;
        if (alu_start !== 1'b1 || alu_op !== 2'b10) begin
            bad++;
            $display("FAIL pre_reset got=start%b op%b exp=1/10",
                     alu_start, alu_op);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (alu_start !== 1'b0 || busy !== 1'b0
            || state_dbg !== 3'd0) begin
            bad++;
            $display("FAIL async_reset got=start%b busy%b st%0d exp=0/0/0",
                     alu_start, busy, state_dbg);
        end
        total++;
        if ({operand_a, operand_b, disp_bcd, alu_op} !== 50'h0) begin
            bad++;
            $display("FAIL async_regs got=%h/%h/%h/%b exp=0",
                     operand_a, operand_b, disp_bcd, alu_op);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(1);
    endtask

    initial begin
        reset      = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'hF;
        alu_done   = 1'b0;
        alu_result = 16'h0;
        alu_ovf    = 1'b0;
        test_reset();
        test_basic_add();
        test_chain_ovf();
        test_digit_drop_timeout();
        test_clear_vs_done();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
